// File: rtl/uart_rx_cfg_pkg.sv
// Shared types for the configurable UART receiver: parity modes and receiver states.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4,
      BRK   = 3'd5
   } state_t;

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Serial line and consumer-side handshake of the UART receiver.
interface uart_rx_cfg_if #(
   parameter int DATA_BITS = 8
) ();

   logic                 RX;
   logic                 clr_rdy;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rdy;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;

   modport slave (
      input  RX, clr_rdy,
      output rx_data, rdy, parity_err, frame_err, overrun
   );

   modport master (
      output RX, clr_rdy,
      input  rx_data, rdy, parity_err, frame_err, overrun
   );

endinterface

// File: rtl/uart_rx_cfg_sync.sv
// Two-flop synchroniser for an asynchronous input, with a configurable reset value.
module uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [1:0] sync_r;

   // Metastability filter chain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= {2{RST_VAL}};
      end else begin
         sync_r <= {sync_r[0], d};
      end
   end

   assign q = sync_r[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, optional parity, 1 or 2 stop bits,
// break hold-off after a framing error, sticky overrun.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int      DATA_BITS = 8,
   parameter int      BAUD_DIV  = 2604,
   parameter parity_t PARITY    = PAR_NONE,
   parameter int      STOP_BITS = 1
) (
   input logic          clk,
   input logic          rst,
   uart_rx_cfg_if.slave bus
);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
   end
   if (BAUD_DIV < 8 || BAUD_DIV > 65535) begin : g_bad_baud_div
      $error("uart_rx_cfg: BAUD_DIV must be 8..65535");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
   end

   localparam logic [15:0] HALF_L      = 16'(BAUD_DIV / 2);
   localparam logic [15:0] FULL_L      = 16'(BAUD_DIV);
   localparam logic [3:0]  LAST_DATA_L = 4'(DATA_BITS - 1);
   localparam logic [3:0]  LAST_STOP_L = 4'(STOP_BITS - 1);
   localparam logic        PAR_EN_L    = (PARITY != PAR_NONE);

   function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input parity_t mode);
      calc_parity = (^d) ^ (mode == PAR_ODD);
   endfunction

   logic                 rx_s;
   state_t               state_r, state_nx_s;
   logic [15:0]          baud_r;
   logic [3:0]           bit_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 par_err_r, frm_r, fin_r;
   logic [DATA_BITS-1:0] rx_data_r;
   logic                 rdy_r, parity_err_r, frame_err_r, overrun_r;
   logic                 cnt_run_s, tick_s, start_ld_s, frame_clr_s;
   logic                 bit_clr_s, bit_inc_s, shift_en_s, par_chk_s;
   logic                 stop_smp_s, fin_set_s, done_s;

   uart_sync #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.RX),
      .q   (rx_s)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE:    state_nx_s = rx_s ? IDLE : START;
         START:   state_nx_s = tick_s ? (rx_s ? IDLE : DATA) : START;
         DATA:    state_nx_s = (tick_s && (bit_r == LAST_DATA_L)) ? (PAR_EN_L ? PAR : STOP) : DATA;
         PAR:     state_nx_s = tick_s ? STOP : PAR;
         STOP:    state_nx_s = fin_r ? (frm_r ? BRK : IDLE) : STOP;
         BRK:     state_nx_s = rx_s ? IDLE : BRK;
         default: state_nx_s = IDLE;
      endcase
   end

   // Per-state datapath controls; a tick is the baud counter running out mid-bit
   always_comb begin
      cnt_run_s   = (state_r == START) || (state_r == DATA) || (state_r == PAR) || (state_r == STOP);
      tick_s      = cnt_run_s && (baud_r == 16'd1);
      start_ld_s  = 1'b0;
      frame_clr_s = 1'b0;
      bit_clr_s   = 1'b0;
      bit_inc_s   = 1'b0;
      shift_en_s  = 1'b0;
      par_chk_s   = 1'b0;
      stop_smp_s  = 1'b0;
      fin_set_s   = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         IDLE: start_ld_s = ~rx_s;
         START: begin
            frame_clr_s = tick_s & ~rx_s;
            bit_clr_s   = tick_s & ~rx_s;
         end
         DATA: begin
            shift_en_s = tick_s;
            bit_clr_s  = tick_s & (bit_r == LAST_DATA_L);
            bit_inc_s  = tick_s & (bit_r != LAST_DATA_L);
         end
         PAR: begin
            par_chk_s = tick_s;
            bit_clr_s = tick_s;
         end
         STOP: begin
            stop_smp_s = tick_s & ~fin_r;
            fin_set_s  = stop_smp_s & (bit_r == LAST_STOP_L);
            bit_inc_s  = stop_smp_s & (bit_r != LAST_STOP_L);
            done_s     = fin_r;
         end
         default: ;
      endcase
   end

   // Baud timing, bit counting, shift register and per-frame error capture
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_r    <= 16'd0;
         bit_r     <= 4'd0;
         shift_r   <= '0;
         par_err_r <= 1'b0;
         frm_r     <= 1'b0;
         fin_r     <= 1'b0;
      end else begin
         if (start_ld_s) begin
            baud_r <= HALF_L;
         end else if (tick_s) begin
            baud_r <= FULL_L;
         end else if (cnt_run_s) begin
            baud_r <= baud_r - 16'd1;
         end
         if (bit_clr_s) begin
            bit_r <= 4'd0;
         end else if (bit_inc_s) begin
            bit_r <= bit_r + 4'd1;
         end
         if (shift_en_s) begin
            shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
         end
         if (frame_clr_s) begin
            par_err_r <= 1'b0;
            frm_r     <= 1'b0;
         end else begin
            if (par_chk_s) begin
               par_err_r <= rx_s ^ calc_parity(shift_r, PARITY);
            end
            if (stop_smp_s && !rx_s) begin
               frm_r <= 1'b1;
            end
         end
         fin_r <= fin_set_s;
      end
   end

   // Consumer-visible result registers; a completing frame outranks clr_rdy
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data_r    <= '0;
         rdy_r        <= 1'b0;
         parity_err_r <= 1'b0;
         frame_err_r  <= 1'b0;
         overrun_r    <= 1'b0;
      end else if (done_s) begin
         rx_data_r    <= shift_r;
         rdy_r        <= 1'b1;
         parity_err_r <= par_err_r;
         frame_err_r  <= frm_r;
         overrun_r    <= bus.clr_rdy ? 1'b0 : (overrun_r | rdy_r);
      end else if (bus.clr_rdy) begin
         rdy_r        <= 1'b0;
         parity_err_r <= 1'b0;
         frame_err_r  <= 1'b0;
         overrun_r    <= 1'b0;
      end
   end

   assign bus.rx_data    = rx_data_r;
   assign bus.rdy        = rdy_r;
   assign bus.parity_err = parity_err_r;
   assign bus.frame_err  = frame_err_r;
   assign bus.overrun    = overrun_r;

endmodule
